// File: rtl/mac_pkg.sv
// Shared constants for the multiply-accumulate + ReLU slice.
package mac_pkg;

    // Default operand / accumulator width in bits.
    localparam int MAC_DW = 32;

    // Full-precision signed product width.
    localparam int MAC_PW = 2 * MAC_DW;

endpackage : mac_pkg

// File: rtl/mac_relu_unit_if.sv
// Signal bundle for driving and observing one mac_relu_unit.
// enable acts as a valid strobe into a sink that is always ready:
// every cycle with enable=1 consumes the a/b pair, there is no back-pressure.
interface mac_relu_unit_if
    import mac_pkg::*;
#(
    parameter int DW = MAC_DW
);
    logic                 mac_rst;
    logic                 enable;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
    logic signed [DW-1:0] acc;
    logic        [DW-1:0] relu_acc;
    logic                 ovf;

    // Stimulus side: drives operands and controls, observes results.
    modport master (
        output mac_rst, enable, a, b,
        input  acc, relu_acc, ovf
    );

    // Design side: consumes operands and controls, produces results.
    modport slave (
        input  mac_rst, enable, a, b,
        output acc, relu_acc, ovf
    );
endinterface : mac_relu_unit_if

// File: rtl/mac_unit.sv
// Two-stage signed multiply-accumulate: stage 1 registers the full product,
// stage 2 folds its low DW bits into a wrapping accumulator and tracks a
// sticky overflow flag.
module mac_unit
    import mac_pkg::*;
#(
    parameter int DW = MAC_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 enable,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] acc,
    output logic                 ovf
);

    localparam int PW = 2 * DW;

    logic [PW-1:0] p_q, p_d;
    logic          p_vld_q, p_vld_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          ovf_q, ovf_d;

    logic [DW-1:0] term;
    logic [DW-1:0] sum;
    logic [DW:0]   p_upper;
    logic          add_ovf;
    logic          prod_ovf;

    // Stage 1 next state: sign-extend both operands so the PW-bit product is exact.
    always_comb begin
        p_d     = {{DW{a[DW-1]}}, a} * {{DW{b[DW-1]}}, b};
        p_vld_d = enable;
    end

    // Stage 2 next state: wrap-around add plus overflow detection on valid terms.
    always_comb begin
        term     = p_q[DW-1:0];
        sum      = acc_q + term;
        // Signed add overflow: equal-sign operands giving an opposite-sign result.
        add_ovf  = (acc_q[DW-1] == term[DW-1]) && (sum[DW-1] != acc_q[DW-1]);
        // The product fits in DW signed bits only if its top DW+1 bits all match.
        p_upper  = p_q[PW-1:DW-1];
        prod_ovf = !((&p_upper) || (p_upper == '0));
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        if (p_vld_q) begin
            acc_d = sum;
            if (add_ovf || prod_ovf) begin
                ovf_d = 1'b1;
            end
        end
    end

    // State registers: rst beats clear, clear beats any new or in-flight term.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            p_vld_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            p_q     <= p_d;
            p_vld_q <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            p_q     <= p_d;
            p_vld_q <= p_vld_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule : mac_unit

// File: rtl/relu_unit.sv
// Combinational ReLU: passes non-negative values, clamps negatives to zero.
module relu_unit
    import mac_pkg::*;
#(
    parameter int DW = MAC_DW
) (
    input  logic signed [DW-1:0] mac_acc,
    output logic        [DW-1:0] relu_acc
);

    // Sign bit selects between the value and zero; no state, no added latency.
    always_comb begin
        relu_acc = mac_acc[DW-1] ? '0 : mac_acc;
    end

endmodule : relu_unit

// File: rtl/mac_relu_unit.sv
// Top level: pipelined multiply-accumulate followed by a ReLU on the
// registered accumulator. Only wiring lives here.
module mac_relu_unit
    import mac_pkg::*;
#(
    parameter int DW = MAC_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mac_rst,
    input  logic                 enable,
    input  logic signed [DW-1:0] a,
    input  logic signed [DW-1:0] b,
    output logic signed [DW-1:0] acc,
    output logic        [DW-1:0] relu_acc,
    output logic                 ovf
);

    mac_unit #(
        .DW(DW)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (mac_rst),
        .enable (enable),
        .a      (a),
        .b      (b),
        .acc    (acc),
        .ovf    (ovf)
    );

    relu_unit #(
        .DW(DW)
    ) u_relu (
        .mac_acc  (acc),
        .relu_acc (relu_acc)
    );

endmodule : mac_relu_unit

// File: tb/tb_mac_relu_unit.sv
// Directed bench for mac_relu_unit: a table of per-cycle inputs with the
// hand-computed accumulator and overflow expected after each edge, plus a
// few hand-written sequences.
module tb_mac_relu_unit;
    import mac_pkg::*;

    localparam int DW = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mac_relu_unit_if #(.DW(DW)) bus ();

    mac_relu_unit #(
        .DW(DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mac_rst  (bus.mac_rst),
        .enable   (bus.enable),
        .a        (bus.a),
        .b        (bus.b),
        .acc      (bus.acc),
        .relu_acc (bus.relu_acc),
        .ovf      (bus.ovf)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic          rst;
        logic          mrst;
        logic          en;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] exp_acc;
        logic          exp_ovf;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void add_vec(input logic r, input logic m, input logic e,
                                    input int av, input int bv,
                                    input int ea, input logic eo);
        vec_t v;
        v.rst     = r;
        v.mrst    = m;
        v.en      = e;
        v.a       = av;
        v.b       = bv;
        v.exp_acc = ea;
        v.exp_ovf = eo;
        vecs.push_back(v);
    endfunction

    // ---------------- driver ----------------
    // Apply one cycle of inputs, then return #1 after the edge that samples them.
    task automatic step(input logic r, input logic m, input logic e,
                        input logic [DW-1:0] av, input logic [DW-1:0] bv);
        rst         = r;
        bus.mac_rst = m;
        bus.enable  = e;
        bus.a       = av;
        bus.b       = bv;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic [DW-1:0] exp_relu;

    initial begin
        rst         = 1'b1;
        bus.mac_rst = 1'b0;
        bus.enable  = 1'b0;
        bus.a       = '0;
        bus.b       = '0;

        // Reset with an enabled pair presented: nothing may leak through.
        step(1, 0, 1, 32'd7, 32'd7);
        step(1, 0, 0, 0, 0);
        check("reset acc", bus.acc, '0);
        check("reset relu", bus.relu_acc, '0);
        check("reset ovf", DW'(bus.ovf), '0);

        // 3x3 edge kernel, positive result. Columns: rst mrst en a b | acc ovf.
        add_vec(0, 1, 0, 0, 0,    0, 0);
        add_vec(0, 0, 1, 1, -1,   0, 0);
        add_vec(0, 0, 1, 2, -1,  -1, 0);
        add_vec(0, 0, 1, 3, -1,  -3, 0);
        add_vec(0, 0, 1, 4, 0,   -6, 0);
        add_vec(0, 0, 1, 5, 0,   -6, 0);
        add_vec(0, 0, 1, 6, 0,   -6, 0);
        add_vec(0, 0, 1, 7, 1,   -6, 0);
        add_vec(0, 0, 1, 8, 1,    1, 0);
        add_vec(0, 0, 1, 9, 1,    9, 0);
        add_vec(0, 0, 0, 0, 0,   18, 0);
        add_vec(0, 0, 0, 0, 0,   18, 0);
        // Rows swapped: negative result, ReLU clamps to zero.
        add_vec(0, 1, 0, 0, 0,    0, 0);
        add_vec(0, 0, 1, 1, 1,    0, 0);
        add_vec(0, 0, 1, 2, 1,    1, 0);
        add_vec(0, 0, 1, 3, 1,    3, 0);
        add_vec(0, 0, 1, 4, 0,    6, 0);
        add_vec(0, 0, 1, 5, 0,    6, 0);
        add_vec(0, 0, 1, 6, 0,    6, 0);
        add_vec(0, 0, 1, 7, -1,   6, 0);
        add_vec(0, 0, 1, 8, -1,  -1, 0);
        add_vec(0, 0, 1, 9, -1,  -9, 0);
        add_vec(0, 0, 0, 0, 0,  -18, 0);
        add_vec(0, 0, 0, 0, 0,  -18, 0);
        // Accumulator overflow, sticky flag, then cleared by mac_rst.
        add_vec(0, 1, 0, 0, 0,             0, 0);
        add_vec(0, 0, 1, 32'h7FFFFFFF, 1,  0, 0);
        add_vec(0, 0, 1, 1, 1,             32'h7FFFFFFF, 0);
        add_vec(0, 0, 0, 0, 0,             32'h80000000, 1);
        add_vec(0, 0, 0, 0, 0,             32'h80000000, 1);
        add_vec(0, 1, 0, 0, 0,             0, 0);
        // Gaps insert nothing; hold for 5 idle cycles.
        add_vec(0, 0, 1, 3, 4,    0, 0);
        add_vec(0, 0, 0, 0, 0,   12, 0);
        add_vec(0, 0, 0, 0, 0,   12, 0);
        add_vec(0, 0, 1, 5, 6,   12, 0);
        add_vec(0, 0, 0, 0, 0,   42, 0);
        for (int k = 0; k < 5; k++) begin
            add_vec(0, 0, 0, 0, 0, 42, 0);
        end
        // mac_rst together with an enabled pair: clear wins, pair discarded.
        add_vec(0, 1, 1, 100, 2,  0, 0);
        add_vec(0, 0, 0, 0, 0,    0, 0);
        add_vec(0, 0, 0, 0, 0,    0, 0);
        // mac_rst with a pair already in stage 1: that term is discarded.
        add_vec(0, 0, 1, 5, 5,    0, 0);
        add_vec(0, 1, 0, 0, 0,    0, 0);
        add_vec(0, 0, 0, 0, 0,    0, 0);
        // rst after 4 pairs (4th still in flight), with enable and mac_rst high.
        add_vec(0, 0, 1, 1, 1,    0, 0);
        add_vec(0, 0, 1, 2, 1,    1, 0);
        add_vec(0, 0, 1, 3, 1,    3, 0);
        add_vec(0, 0, 1, 4, 1,    6, 0);
        add_vec(1, 1, 1, 10, 10,  0, 0);
        add_vec(0, 0, 0, 0, 0,    0, 0);
        add_vec(0, 0, 0, 0, 0,    0, 0);
        add_vec(0, 0, 1, 2, 3,    0, 0);
        add_vec(0, 0, 0, 0, 0,    6, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].mrst, vecs[i].en, vecs[i].a, vecs[i].b);
            exp_relu = vecs[i].exp_acc[DW-1] ? '0 : vecs[i].exp_acc;
            check($sformatf("v%0d acc", i), bus.acc, vecs[i].exp_acc);
            check($sformatf("v%0d relu", i), bus.relu_acc, exp_relu);
            check($sformatf("v%0d ovf", i), DW'(bus.ovf), DW'(vecs[i].exp_ovf));
        end

        // Product too wide for DW bits: 2^16 * 2^16 = 2^32, low word is zero.
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 32'h00010000, 32'h00010000);
        step(0, 0, 0, 0, 0);
        check("wide product acc", bus.acc, '0);
        check("wide product ovf", DW'(bus.ovf), 32'd1);
        // Most negative times -1 also does not fit; low word wraps to 0x80000000.
        step(0, 0, 1, 32'h80000000, 32'hFFFFFFFF);
        step(0, 0, 0, 0, 0);
        check("minneg product acc", bus.acc, 32'h80000000);
        check("minneg product relu", bus.relu_acc, '0);
        // rst clears the sticky flag too.
        step(1, 0, 0, 0, 0);
        check("rst clears ovf", DW'(bus.ovf), '0);
        check("rst clears acc", bus.acc, '0);
        step(0, 0, 1, 32'hFFFFFFFD, 32'd5);
        step(0, 0, 0, 0, 0);
        check("resume neg acc", bus.acc, 32'hFFFFFFF1);
        check("resume neg relu", bus.relu_acc, '0);
        check("resume neg ovf", DW'(bus.ovf), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mac_relu_unit

// File: doc/mac_relu_unit.md
MAC_RELU_UNIT -- requirements
Module: mac_relu_unit

Interface
REQ-001 The block SHALL have one parameter line: DW, default 32, operand/accumulator width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port mac_rst, input, 1 bit: synchronous accumulator clear, active-high.
REQ-005 The block SHALL have port enable, input, 1 bit: high marks a and b as a valid operand pair this cycle.
REQ-006 The block SHALL have port a, input, DW bits, signed two's complement: data operand.
REQ-007 The block SHALL have port b, input, DW bits, signed two's complement: weight operand.
REQ-008 The block SHALL have port acc, output, DW bits, signed: registered accumulator value.
REQ-009 The block SHALL have port relu_acc, output, DW bits: ReLU of acc.
REQ-010 The block SHALL have port ovf, output, 1 bit: sticky accumulator-overflow flag.

Function
REQ-011 Stage 1 SHALL register the full 2*DW-bit signed product p = a*b and a valid bit (p_vld = enable) every cycle.
REQ-012 Stage 2 SHALL, when p_vld=1, update acc <= acc + low DW bits of p, wrapping modulo 2^DW; when p_vld=0, acc SHALL hold.
REQ-013 Latency SHALL be 2 cycles: a pair sampled with enable at edge N is reflected in acc after edge N+1; acc is final 2 cycles after the last enabled edge.
REQ-014 Back-to-back enables SHALL be accepted every cycle with no stall; enable gaps SHALL insert no spurious terms.
REQ-015 mac_rst=1 SHALL set acc=0, p_vld=0 and ovf=0 at the next edge, discarding any pair presented with or in flight before it; clear wins over a simultaneous enable.
REQ-016 ovf SHALL set when a stage-2 add has signed overflow (operands of equal sign, result of opposite sign) or when p does not fit in DW signed bits; it SHALL remain set until mac_rst or rst.
REQ-017 relu_acc SHALL be combinational from acc: acc when acc[DW-1]=0, else 0; it SHALL add no latency.
REQ-018 acc, relu_acc and ovf SHALL be glitch-free registered/derived values, stable from edge to edge.

Reset
REQ-019 rst=1 SHALL, at the next edge, set acc=0, ovf=0, p_vld=0 and the product register to 0, giving relu_acc=0.
REQ-020 rst SHALL take priority over mac_rst and enable, including mid-accumulation; operation SHALL resume on the first edge after rst deasserts.

Structure
REQ-021 DW and the product width 2*DW SHALL be defined as constants in a shared package mac_pkg; no typedefs are required.
REQ-022 The two-stage multiply-accumulate SHALL be sub-module mac_unit with ports clk, rst, enable, a, b, acc; mac_rst SHALL be connected to its clear input.
REQ-023 The ReLU SHALL be the combinational sub-module relu_unit (ports mac_acc in, relu_acc out); mac_relu_unit SHALL only instantiate and wire mac_unit and relu_unit.

Verification
REQ-024 The bench SHALL cover a 3x3 edge kernel: mac_rst pulse, then 9 enabled pairs (1,-1),(2,-1),(3,-1),(4,0),(5,0),(6,0),(7,1),(8,1),(9,1) -> acc=18, relu_acc=18 two cycles after the last pair, ovf=0.
REQ-025 The bench SHALL cover a negative result with the same kernel and rows swapped (7,8,9 weighted -1; 1,2,3 weighted +1) -> acc=-18, relu_acc=0.
REQ-026 The bench SHALL cover overflow: pairs (0x7FFFFFFF,1) then (1,1) -> acc=0x80000000, ovf=1, relu_acc=0; then a mac_rst pulse -> acc=0, ovf=0.
REQ-027 The bench SHALL cover gaps and hold: pairs (3,4), idle for 2 cycles, then (5,6) -> acc=42; with enable held low for 5 cycles acc stays 42.
REQ-028 The bench SHALL cover clear/reset races: mac_rst asserted together with enable and (100,2) -> acc=0; rst asserted mid-sequence after 4 pairs -> acc=0 at the next edge and no in-flight term appears afterward.
